// File: rtl/ace_instbuf.sv
// ace_instbuf - decode-stage-0 instruction buffer.
//
// Takes the registered 8-lane fetch bundle, compacts its valid lanes in lane
// order into a circular queue, and presents the two oldest entries to decode.
// Drives back-pressure to fetch with enough headroom for the two bundles that
// may already be in flight, so the queue cannot overflow.
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-high reset
//   inst_vld_d0_i[7:0]      lane valid bits (bit k = lane k)
//   inst_d0_i[255:0]        lane k instruction in [32k+31:32k]
//   flush_rt_i              retire flush, drops buffered and incoming lanes
//   dec_stall_i             decode cannot take instructions this cycle
//   instbuf_full_o          back-pressure to fetch
//   dec0_vld_o/dec0_inst_o  oldest entry
//   dec1_vld_o/dec1_inst_o  second-oldest entry
//   instbuf_cnt_o           current occupancy
//
// Build option: define ACE_INSTBUF_BYPASS_EN to let an accepted bundle arriving
// at an empty, unstalled buffer drive decode in the same cycle.
module ace_instbuf #(
    parameter int DEPTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               inst_vld_d0_i,
    input  logic [255:0]             inst_d0_i,
    input  logic                     flush_rt_i,
    input  logic                     dec_stall_i,
    output logic                     instbuf_full_o,
    output logic                     dec0_vld_o,
    output logic                     dec1_vld_o,
    output logic [31:0]              dec0_inst_o,
    output logic [31:0]              dec1_inst_o,
    output logic [$clog2(DEPTH):0]   instbuf_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          acc_q, acc_d;

    // Entry storage; intentionally not reset.
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic [3:0]    lane_off [8];   // compacted slot of each lane
    logic [3:0]    enq_n;
    logic [3:0]    skip_n;         // leading lanes consumed by bypass
    logic [3:0]    wr_n;
    logic [7:0]    wr_en;
    logic [AW-1:0] wr_addr [8];
    logic [1:0]    deq_n;
    logic          byp;

    // Fetch holds stale data after a full cycle; acc_q screens it out.
    assign accept         = acc_q & ~flush_rt_i;
    assign instbuf_full_o = (count_q > CW'(DEPTH - 16));
    assign instbuf_cnt_o  = count_q;

    // Prefix popcount: lane k lands at tail + number of valid lanes below it.
    always_comb begin : compaction
        logic [3:0] run;
        run = 4'd0;
        for (int k = 0; k < 8; k++) begin
            lane_off[k] = run;
            run         = run + {3'b000, inst_vld_d0_i[k]};
        end
        enq_n = run;
    end

`ifdef ACE_INSTBUF_BYPASS_EN
    logic [31:0] byp_inst0, byp_inst1;

    assign byp = (count_q == '0) & accept & ~dec_stall_i;

    // First and second compacted incoming lanes.
    always_comb begin
        byp_inst0 = 32'd0;
        byp_inst1 = 32'd0;
        for (int k = 0; k < 8; k++) begin
            if (inst_vld_d0_i[k] && lane_off[k] == 4'd0) byp_inst0 = inst_d0_i[32*k +: 32];
            if (inst_vld_d0_i[k] && lane_off[k] == 4'd1) byp_inst1 = inst_d0_i[32*k +: 32];
        end
    end
`else
    assign byp = 1'b0;
`endif

    assign skip_n = byp ? ((enq_n > 4'd2) ? 4'd2 : enq_n) : 4'd0;
    assign wr_n   = accept ? (enq_n - skip_n) : 4'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign wr_en[gi]   = accept & inst_vld_d0_i[gi] & (lane_off[gi] >= skip_n);
            assign wr_addr[gi] = tail_q + AW'(lane_off[gi] - skip_n);
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int k = 0; k < 8; k++) begin
            if (wr_en[k]) mem[wr_addr[k]] <= inst_d0_i[32*k +: 32];
        end
    end

    // Decode side: both presented entries are taken together or not at all.
    always_comb begin
        dec0_vld_o  = (count_q >= CW'(1)) & ~flush_rt_i;
        dec1_vld_o  = (count_q >= CW'(2)) & ~flush_rt_i;
        dec0_inst_o = mem[head_q];
        dec1_inst_o = mem[head_q + AW'(1)];
        deq_n       = 2'd0;
        if (!dec_stall_i) deq_n = {1'b0, dec0_vld_o} + {1'b0, dec1_vld_o};
`ifdef ACE_INSTBUF_BYPASS_EN
        if (byp) begin
            dec0_vld_o  = (enq_n >= 4'd1);
            dec1_vld_o  = (enq_n >= 4'd2);
            dec0_inst_o = byp_inst0;
            dec1_inst_o = byp_inst1;
            deq_n       = 2'd0;   // bypassed lanes never enter the queue
        end
`endif
    end

    always_comb begin
        head_d  = head_q + AW'(deq_n);
        tail_d  = tail_q + AW'(wr_n);
        count_d = count_q + CW'(wr_n) - CW'(deq_n);
        acc_d   = ~instbuf_full_o;
        if (flush_rt_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            acc_d   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            acc_q   <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_ace_instbuf.sv
// tb_ace_instbuf - self-checking bench for ace_instbuf.
// Directed scenarios plus a randomized run compared against a queue-based
// reference model of the buffer's behaviour.
module tb_ace_instbuf;

    localparam int DEPTH = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   inst_vld_d0_i;
    logic [255:0] inst_d0_i;
    logic         flush_rt_i;
    logic         dec_stall_i;
    logic         instbuf_full_o;
    logic         dec0_vld_o, dec1_vld_o;
    logic [31:0]  dec0_inst_o, dec1_inst_o;
    logic [5:0]   instbuf_cnt_o;

    ace_instbuf #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .inst_vld_d0_i  (inst_vld_d0_i),
        .inst_d0_i      (inst_d0_i),
        .flush_rt_i     (flush_rt_i),
        .dec_stall_i    (dec_stall_i),
        .instbuf_full_o (instbuf_full_o),
        .dec0_vld_o     (dec0_vld_o),
        .dec1_vld_o     (dec1_vld_o),
        .dec0_inst_o    (dec0_inst_o),
        .dec1_inst_o    (dec1_inst_o),
        .instbuf_cnt_o  (instbuf_cnt_o)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents plus the "fetch data is fresh" flag.
    logic [31:0] mq[$];
    bit          m_acc;

    // Expected and observed values for the most recent cycle.
    int          e_cnt, o_cnt;
    bit          e_full, e_v0, e_v1, o_full, o_v0, o_v1;
    logic [31:0] e_i0, e_i1, o_i0, o_i1;

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = base + 32'(k);
        return r;
    endfunction

    // Drive one cycle of inputs, capture expected (model) and observed outputs
    // mid-cycle, then advance the model across the clock edge.
    task automatic cycle(input logic [7:0] v, input logic [255:0] d, input bit fl, input bit st);
        logic [31:0] inc[$];
        bit byp;
        int skip;
        inst_vld_d0_i = v;
        inst_d0_i     = d;
        flush_rt_i    = fl;
        dec_stall_i   = st;
        for (int k = 0; k < 8; k++) if (v[k]) inc.push_back(d[32*k +: 32]);
        e_cnt  = mq.size();
        e_full = (e_cnt > DEPTH - 16);
        e_v0   = (e_cnt >= 1) && !fl;
        e_v1   = (e_cnt >= 2) && !fl;
        e_i0   = (e_cnt >= 1) ? mq[0] : 32'd0;
        e_i1   = (e_cnt >= 2) ? mq[1] : 32'd0;
        byp    = 1'b0;
`ifdef ACE_INSTBUF_BYPASS_EN
        if (e_cnt == 0 && m_acc && !fl && !st) begin
            byp  = 1'b1;
            e_v0 = (inc.size() >= 1);
            e_v1 = (inc.size() >= 2);
            e_i0 = (inc.size() >= 1) ? inc[0] : 32'd0;
            e_i1 = (inc.size() >= 2) ? inc[1] : 32'd0;
        end
`endif
        @(negedge clock);
        o_cnt  = int'(instbuf_cnt_o);
        o_full = instbuf_full_o;
        o_v0   = dec0_vld_o;
        o_v1   = dec1_vld_o;
        o_i0   = dec0_inst_o;
        o_i1   = dec1_inst_o;
        @(posedge clock);
        if (fl) begin
            mq.delete();
            m_acc = 1'b1;
        end else begin
            if (!st && !byp) begin
                if (e_v0) void'(mq.pop_front());
                if (e_v1) void'(mq.pop_front());
            end
            skip = byp ? 2 : 0;
            if (m_acc) begin
                foreach (inc[i]) begin
                    if (skip > 0) skip--;
                    else mq.push_back(inc[i]);
                end
            end
            m_acc = !e_full;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        inst_vld_d0_i = 8'h00;
        flush_rt_i = 1'b0;
        dec_stall_i = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        m_acc = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        inst_vld_d0_i = 8'h00;
        inst_d0_i = '0;
        flush_rt_i = 1'b0;
        dec_stall_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        m_acc = 1'b1;
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", o_cnt); end
        total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", o_full); end
        total++; if (o_v0 !== 1'b0) begin bad++; $display("FAIL reset_v0 got=%0b want=0", o_v0); end
        total++; if (o_v1 !== 1'b0) begin bad++; $display("FAIL reset_v1 got=%0b want=0", o_v1); end
        $display("test_reset: cnt=%0d full=%0b", o_cnt, o_full);
    endtask

    task automatic test_compaction();
        cycle(8'hA5, mk(32'h100), 1'b0, 1'b1);
        cycle(8'h00, '0, 1'b0, 1'b1);
        total++; if (o_cnt !== 4) begin bad++; $display("FAIL compact_cnt got=%0d want=4", o_cnt); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (!(o_v0 && o_v1)) begin bad++; $display("FAIL compact_vld1 got=%0b%0b want=11", o_v0, o_v1); end
        total++; if (o_i0 !== 32'h100) begin bad++; $display("FAIL compact_i0a got=%h want=100", o_i0); end
        total++; if (o_i1 !== 32'h102) begin bad++; $display("FAIL compact_i1a got=%h want=102", o_i1); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_i0 !== 32'h105) begin bad++; $display("FAIL compact_i0b got=%h want=105", o_i0); end
        total++; if (o_i1 !== 32'h107) begin bad++; $display("FAIL compact_i1b got=%h want=107", o_i1); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 0) begin bad++; $display("FAIL compact_drain got=%0d want=0", o_cnt); end
        $display("test_compaction: final cnt=%0d", o_cnt);
    endtask

    task automatic test_full();
        int exp_cnt [6] = '{0, 8, 16, 24, 32, 32};
        bit exp_full[6] = '{0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            cycle(8'hFF, mk(32'h500 + 32'(8*i)), 1'b0, 1'b1);
            total++; if (o_cnt !== exp_cnt[i]) begin bad++; $display("FAIL full_cnt%0d got=%0d want=%0d", i, o_cnt, exp_cnt[i]); end
            total++; if (o_full !== exp_full[i]) begin bad++; $display("FAIL full_flag%0d got=%0b want=%0b", i, o_full, exp_full[i]); end
        end
        // Reset mid-operation must restore acceptance even though acc was low.
        apply_reset();
        cycle(8'hFF, mk(32'h600), 1'b0, 1'b1);
        total++; if (o_cnt !== 0) begin bad++; $display("FAIL full_rst_cnt got=%0d want=0", o_cnt); end
        cycle(8'h00, '0, 1'b0, 1'b1);
        total++; if (o_cnt !== 8) begin bad++; $display("FAIL full_rst_acc got=%0d want=8", o_cnt); end
        for (int i = 0; i < 5; i++) begin
            cycle(8'h00, '0, 1'b0, 1'b0);
            total++; if (o_v0 && o_i0 !== e_i0) begin bad++; $display("FAIL full_drain%0d got=%h want=%h", i, o_i0, e_i0); end
        end
        $display("test_full: after drain cnt=%0d", o_cnt);
    endtask

    task automatic test_wrap();
        logic [31:0] p  = 32'h1000;
        logic [31:0] nx = 32'h1000;
        for (int r = 0; r < 10; r++) begin
            cycle(8'hFF, mk(p), 1'b0, 1'b1);
            p += 32'd8;
            for (int j = 0; j < 4; j++) begin
                cycle(8'h00, '0, 1'b0, 1'b0);
                total++;
                if (!(o_v0 && o_v1) || o_i0 !== nx || o_i1 !== nx + 32'd1) begin
                    bad++;
                    $display("FAIL wrap_r%0d_%0d got=%0b%0b %h %h want=11 %h %h", r, j, o_v0, o_v1, o_i0, o_i1, nx, nx + 32'd1);
                end
                nx += 32'd2;
            end
        end
        $display("test_wrap: last expected=%h", nx - 32'd1);
    endtask

    task automatic test_flush();
        cycle(8'hFF, mk(32'h2000), 1'b0, 1'b1);
        cycle(8'h0F, mk(32'h2100), 1'b0, 1'b1);
        cycle(8'hFF, mk(32'h2200), 1'b1, 1'b0);
        total++; if (o_cnt !== 12) begin bad++; $display("FAIL flush_pre_cnt got=%0d want=12", o_cnt); end
        total++; if (o_v0 !== 1'b0 || o_v1 !== 1'b0) begin bad++; $display("FAIL flush_vld got=%0b%0b want=00", o_v0, o_v1); end
        cycle(8'h03, mk(32'h2300), 1'b0, 1'b1);
        total++; if (o_cnt !== 0) begin bad++; $display("FAIL flush_cnt got=%0d want=0", o_cnt); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 2) begin bad++; $display("FAIL flush_accept got=%0d want=2", o_cnt); end
        total++; if (o_i0 !== 32'h2300 || o_i1 !== 32'h2301) begin bad++; $display("FAIL flush_data got=%h %h want=2300 2301", o_i0, o_i1); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        $display("test_flush: cnt=%0d", o_cnt);
    endtask

    task automatic test_odd();
        cycle(8'h01, mk(32'h3000), 1'b0, 1'b1);
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_v0 !== 1'b1 || o_v1 !== 1'b0) begin bad++; $display("FAIL odd_vld got=%0b%0b want=10", o_v0, o_v1); end
        total++; if (o_i0 !== 32'h3000) begin bad++; $display("FAIL odd_data got=%h want=3000", o_i0); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 0) begin bad++; $display("FAIL odd_cnt got=%0d want=0", o_cnt); end
        $display("test_odd: cnt=%0d", o_cnt);
    endtask

    task automatic test_bypass();
        cycle(8'h07, mk(32'h4000), 1'b0, 1'b0);
`ifdef ACE_INSTBUF_BYPASS_EN
        total++; if (o_v0 !== 1'b1 || o_v1 !== 1'b1) begin bad++; $display("FAIL byp_vld got=%0b%0b want=11", o_v0, o_v1); end
        total++; if (o_i0 !== 32'h4000 || o_i1 !== 32'h4001) begin bad++; $display("FAIL byp_data got=%h %h want=4000 4001", o_i0, o_i1); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 1) begin bad++; $display("FAIL byp_cnt got=%0d want=1", o_cnt); end
        total++; if (o_i0 !== 32'h4002) begin bad++; $display("FAIL byp_rest got=%h want=4002", o_i0); end
`else
        total++; if (o_v0 !== 1'b0) begin bad++; $display("FAIL nobyp_vld got=%0b want=0", o_v0); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 3) begin bad++; $display("FAIL nobyp_cnt got=%0d want=3", o_cnt); end
        total++; if (o_i0 !== 32'h4000 || o_i1 !== 32'h4001) begin bad++; $display("FAIL nobyp_data got=%h %h want=4000 4001", o_i0, o_i1); end
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 1) begin bad++; $display("FAIL nobyp_cnt2 got=%0d want=1", o_cnt); end
`endif
        cycle(8'h00, '0, 1'b0, 1'b0);
        total++; if (o_cnt !== 0) begin bad++; $display("FAIL byp_drain got=%0d want=0", o_cnt); end
        $display("test_bypass: cnt=%0d", o_cnt);
    endtask

    task automatic test_random();
        logic [255:0] d;
        int errs0 = bad;
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
            cycle(8'($urandom), d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0));
            total++; if (o_cnt !== e_cnt) begin bad++; $display("FAIL rnd_cnt@%0d got=%0d want=%0d", n, o_cnt, e_cnt); end
            total++; if (o_full !== e_full) begin bad++; $display("FAIL rnd_full@%0d got=%0b want=%0b", n, o_full, e_full); end
            total++; if (o_v0 !== e_v0 || o_v1 !== e_v1) begin bad++; $display("FAIL rnd_vld@%0d got=%0b%0b want=%0b%0b", n, o_v0, o_v1, e_v0, e_v1); end
            if (e_v0) begin
                total++; if (o_i0 !== e_i0) begin bad++; $display("FAIL rnd_i0@%0d got=%h want=%h", n, o_i0, e_i0); end
            end
            if (e_v1) begin
                total++; if (o_i1 !== e_i1) begin bad++; $display("FAIL rnd_i1@%0d got=%h want=%h", n, o_i1, e_i1); end
            end
        end
        $display("test_random: 500 cycles, new bad=%0d", bad - errs0);
    endtask

    initial begin
        test_reset();
        test_compaction();
        test_full();
        test_wrap();
        test_flush();
        test_odd();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

endmodule
